// File: rtl/regfile_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// regfile_hazard_ctrl : decode issue/hazard control for a 16x16 register file.
// Countdown scoreboard plus writeback slot pipe; optional macro HAZARD_FWD_EN.
// Rev 1.0
// ============================================================================
module regfile_hazard_ctrl #(
    parameter int NREG     = 16,
    parameter int WB_LAT   = 3,
    parameter int LOAD_LAT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [15:0]              i_inst,
    input  logic                     i_use_src2,
    input  logic                     i_reg_write,
    input  logic                     i_is_load,
    input  logic                     i_flush,
    output logic                     o_issue,
    output logic                     o_stall,
    output logic [NREG-1:0]          o_busy,
    output logic                     o_wb_en,
`ifdef HAZARD_FWD_EN
    output logic                     o_fwd1,
    output logic                     o_fwd2,
`endif
    output logic [$clog2(NREG)-1:0]  o_wb_add
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(LOAD_LAT + 1);

    logic [CW-1:0] cnt_q    [NREG];
    logic [CW-1:0] cnt_d    [NREG];
    logic          slot_v_q [1:LOAD_LAT];
    logic          slot_v_d [1:LOAD_LAT];
    logic [AW-1:0] slot_a_q [1:LOAD_LAT];
    logic [AW-1:0] slot_a_d [1:LOAD_LAT];

    logic [AW-1:0] w_src1;
    logic [AW-1:0] w_src2;
    logic [AW-1:0] w_dest;
    logic [CW-1:0] w_lat;
    logic [CW-1:0] w_cnt1;
    logic [CW-1:0] w_cnt2;
    logic [CW-1:0] w_cntd;
    logic          w_raw;
    logic          w_waw;
    logic          w_port;
    logic          w_hazard;
    logic          w_go;
    logic          w_wr;
    logic          w_unused_inst;

    assign w_src1        = i_inst[8 +: AW];
    assign w_src2        = i_inst[4 +: AW];
    assign w_dest        = i_inst[0 +: AW];
    assign w_unused_inst = &{1'b0, i_inst[15:12]};

    assign w_lat  = i_is_load ? CW'(LOAD_LAT) : CW'(WB_LAT);
    assign w_cnt1 = cnt_q[w_src1];
    assign w_cnt2 = cnt_q[w_src2];
    assign w_cntd = cnt_q[w_dest];

`ifdef HAZARD_FWD_EN
    // A count of 1 means the value is on the RF write port this cycle, so decode can bypass it.
    assign w_raw  = (w_cnt1 > CW'(1)) | (i_use_src2 & (w_cnt2 > CW'(1)));
    assign o_fwd1 = o_issue & (w_cnt1 == CW'(1));
    assign o_fwd2 = o_issue & i_use_src2 & (w_cnt2 == CW'(1));
`else
    assign w_raw  = (w_cnt1 != '0) | (i_use_src2 & (w_cnt2 != '0));
`endif

    assign w_waw = i_reg_write & (w_cntd != '0);
    // An ALU write issued now would reach slot 1 on the same cycle as whatever sits in slot WB_LAT+1.
    assign w_port = i_reg_write & ~i_is_load & slot_v_q[WB_LAT+1];

    assign w_hazard = w_raw | w_waw | w_port;
    assign w_go     = i_valid & ~i_flush;
    assign o_issue  = w_go & ~w_hazard;
    assign o_stall  = w_go & w_hazard;
    assign w_wr     = o_issue & i_reg_write;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
            if (w_wr && (w_dest == AW'(r))) begin
                cnt_d[r] = w_lat;
            end
        end
        for (int k = 1; k < LOAD_LAT; k++) begin
            slot_v_d[k] = slot_v_q[k+1];
            slot_a_d[k] = slot_a_q[k+1];
        end
        slot_v_d[LOAD_LAT] = 1'b0;
        slot_a_d[LOAD_LAT] = '0;
        for (int k = 1; k <= LOAD_LAT; k++) begin
            if (w_wr && (w_lat == CW'(k))) begin
                slot_v_d[k] = 1'b1;
                slot_a_d[k] = w_dest;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            for (int k = 1; k <= LOAD_LAT; k++) begin
                slot_v_q[k] <= 1'b0;
                slot_a_q[k] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            slot_v_q <= slot_v_d;
            slot_a_q <= slot_a_d;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_busy
        assign o_busy[r] = |cnt_q[r];
    end

    assign o_wb_en  = slot_v_q[1];
    assign o_wb_add = slot_a_q[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_regfile_hazard_ctrl : directed + random checks against a cycle-time model.
// Rev 1.0
// ============================================================================
module tb_regfile_hazard_ctrl;
    localparam int WB_LAT   = 3;
    localparam int LOAD_LAT = 4;
`ifdef HAZARD_FWD_EN
    localparam int THR    = 1;
    localparam int EXP_T3 = 2;
`else
    localparam int THR    = 0;
    localparam int EXP_T3 = 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid, i_use_src2, i_reg_write, i_is_load, i_flush;
    logic [15:0] i_inst;
    logic        o_issue, o_stall, o_wb_en;
    logic [15:0] o_busy;
    logic [3:0]  o_wb_add;
`ifdef HAZARD_FWD_EN
    logic        o_fwd1, o_fwd2;
`endif

    always #5 clk = ~clk;

    regfile_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .i_inst      (i_inst),
        .i_use_src2  (i_use_src2),
        .i_reg_write (i_reg_write),
        .i_is_load   (i_is_load),
        .i_flush     (i_flush),
        .o_issue     (o_issue),
        .o_stall     (o_stall),
        .o_busy      (o_busy),
        .o_wb_en     (o_wb_en),
`ifdef HAZARD_FWD_EN
        .o_fwd1      (o_fwd1),
        .o_fwd2      (o_fwd2),
`endif
        .o_wb_add    (o_wb_add)
    );

    // Model: a register is free from ready_at[r] on; writebacks are a list of (cycle, addr).
    typedef struct {
        int due;
        int addr;
    } wb_t;

    int   cyc = 0;
    int   ready_at [16];
    wb_t  wbq [$];
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_issue;
    logic obs_issue, obs_stall;
    int   wb2_pulses = 0;

    function automatic int cnt_m(int r);
        return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
    endfunction

    function automatic logic [15:0] mk(int s1, int s2, int d);
        return {4'h0, 4'(s1), 4'(s2), 4'(d)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic compare();
        int          s1, s2, d;
        logic        raw, waw, port, exp_stall, wben;
        logic [15:0] busy;
        logic [3:0]  wadd;
        s1   = int'(i_inst[11:8]);
        s2   = int'(i_inst[7:4]);
        d    = int'(i_inst[3:0]);
        raw  = (cnt_m(s1) > THR) || (i_use_src2 && (cnt_m(s2) > THR));
        waw  = i_reg_write && (cnt_m(d) != 0);
        port = 1'b0;
        if (i_reg_write && !i_is_load) begin
            foreach (wbq[j]) if (wbq[j].due == cyc + WB_LAT) port = 1'b1;
        end
        exp_issue = i_valid && !i_flush && !(raw || waw || port);
        exp_stall = i_valid && !i_flush && (raw || waw || port);
        for (int r = 0; r < 16; r++) busy[r] = (cnt_m(r) != 0);
        wben = 1'b0;
        wadd = 4'd0;
        foreach (wbq[j]) begin
            if (wbq[j].due == cyc) begin
                wben = 1'b1;
                wadd = 4'(wbq[j].addr);
            end
        end
        check("issue",  o_issue,  exp_issue);
        check("stall",  o_stall,  exp_stall);
        check("busy",   o_busy,   busy);
        check("wb_en",  o_wb_en,  wben);
        check("wb_add", o_wb_add, wadd);
`ifdef HAZARD_FWD_EN
        check("fwd1", o_fwd1, exp_issue && (cnt_m(s1) == 1));
        check("fwd2", o_fwd2, exp_issue && i_use_src2 && (cnt_m(s2) == 1));
`endif
        obs_issue = o_issue;
        obs_stall = o_stall;
        if (o_wb_en === 1'b1 && o_wb_add === 4'd2) wb2_pulses++;
    endtask

    task automatic model_update();
        int  d, lat;
        wb_t keep [$];
        d = int'(i_inst[3:0]);
        if (exp_issue && i_reg_write) begin
            lat          = i_is_load ? LOAD_LAT : WB_LAT;
            ready_at[d]  = cyc + lat + 1;
            wbq.push_back('{due: cyc + lat, addr: d});
        end
        cyc++;
        foreach (wbq[j]) if (wbq[j].due >= cyc) keep.push_back(wbq[j]);
        wbq = keep;
    endtask

    task automatic step(input logic v, input logic [15:0] inst, input logic u2,
                        input logic rw, input logic ld, input logic fl);
        i_valid     = v;
        i_inst      = inst;
        i_use_src2  = u2;
        i_reg_write = rw;
        i_is_load   = ld;
        i_flush     = fl;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        #1;
        check("rst_busy",   o_busy,   16'h0);
        check("rst_wb_en",  o_wb_en,  1'b0);
        check("rst_wb_add", o_wb_add, 4'h0);
        check("rst_issue",  o_issue,  1'b0);
        check("rst_stall",  o_stall,  1'b0);
        foreach (ready_at[r]) ready_at[r] = 0;
        wbq.delete();
        @(posedge clk);
        cyc++;
        #1 reset = 1'b1;
    endtask

    initial begin
        int   stalls;
        logic got;
        i_valid = 0; i_inst = 0; i_use_src2 = 0; i_reg_write = 0; i_is_load = 0; i_flush = 0;
        #1 do_reset();
        idle(2);

        // ALU write to r3: writeback three cycles later
        step(1, mk(0, 0, 3), 0, 1, 0, 0);
        idle(4);

        // back-to-back RAW on r3
        step(1, mk(0, 0, 3), 0, 1, 0, 0);
        stalls = 0;
        got    = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step(1, mk(3, 0, 7), 0, 1, 0, 0);
            if (obs_issue === 1'b1) got = 1'b1;
            else if (obs_stall === 1'b1) stalls++;
        end
        check("t3_issued", got, 1'b1);
        check("t3_stalls", stalls, EXP_T3);
        idle(5);

        // load r5 then ALU r6: one write-port stall
        step(1, mk(0, 0, 5), 0, 1, 1, 0);
        stalls = 0;
        got    = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step(1, mk(0, 0, 6), 0, 1, 0, 0);
            if (obs_issue === 1'b1) got = 1'b1;
            else if (obs_stall === 1'b1) stalls++;
        end
        check("t4_stalls", stalls, 1);
        idle(6);

        // WAW on r2: load then ALU, two writebacks
        wb2_pulses = 0;
        step(1, mk(0, 0, 2), 0, 1, 1, 0);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step(1, mk(0, 0, 2), 0, 1, 0, 0);
            if (obs_issue === 1'b1) got = 1'b1;
        end
        idle(6);
        check("t5_wb_pulses", wb2_pulses, 2);

        // flush while a RAW hazard is pending
        step(1, mk(0, 0, 9), 0, 1, 0, 0);
        step(1, mk(9, 9, 10), 1, 1, 0, 1);
        check("t6_stall", obs_stall, 1'b0);
        idle(4);

        // reset with the slot pipe populated
        step(1, mk(0, 0, 1), 0, 1, 1, 0);
        step(1, mk(0, 0, 4), 0, 1, 1, 0);
        step(1, mk(0, 0, 8), 0, 1, 0, 0);
        do_reset();
        idle(6);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
